// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1:N stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } demux_state_t;

    // Select width for n channels; at least one bit even for degenerate n.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel with valid/ready handshake.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              slot_free
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    // A write in the same cycle as a drain wins, so valid stays high with the new beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
            last_d  = wr_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1:N packet demultiplexer: routes by the first-beat select, locks the
// route until the last beat, and drops/counts packets with an out-of-range select.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = sel_w(NUM_CH),
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic                     err_sel,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int SEL_SPAN = 1 << SEL_W;

    demux_state_t      state_q, state_d;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              err_sel_q, err_sel_d;

    logic [NUM_CH-1:0]   slot_free;
    logic [NUM_CH-1:0]   wr_en;
    logic [SEL_SPAN-1:0] free_pad;
    logic [SEL_W-1:0]    tgt_sel;
    logic                sel_bad;
    logic                route_beat;
    logic                accept;

    // Unused select codes (non-power-of-two NUM_CH) read as never free.
    always_comb begin
        free_pad = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            free_pad[i] = slot_free[i];
        end
    end

    assign sel_bad = ({{(32-SEL_W){1'b0}}, in_sel} >= 32'(NUM_CH));
    assign tgt_sel = (state_q == IDLE) ? in_sel : cur_sel_q;
    assign accept  = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        drop_cnt_d = drop_cnt_q;
        err_sel_d  = 1'b0;
        in_ready   = 1'b0;
        route_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (sel_bad) begin
                        in_ready  = 1'b1;
                        err_sel_d = 1'b1;
                        if (drop_cnt_q != {CNT_W{1'b1}}) begin
                            drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        end
                        if (!in_last) begin
                            state_d = DROP;
                        end
                    end else begin
                        in_ready   = free_pad[in_sel];
                        route_beat = 1'b1;
                        if (in_ready && !in_last) begin
                            cur_sel_d = in_sel;
                            state_d   = ROUTE;
                        end
                    end
                end
            end
            ROUTE: begin
                in_ready   = free_pad[cur_sel_q];
                route_beat = 1'b1;
                if (in_valid && in_ready && in_last) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = accept && route_beat && (tgt_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_sel_q  <= '0;
            drop_cnt_q <= '0;
            err_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            drop_cnt_q <= drop_cnt_d;
            err_sel_q  <= err_sel_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_out_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[i]),
            .wr_data  (in_data),
            .wr_last  (in_last),
            .out_ready(out_ready[i]),
            .out_valid(out_valid[i]),
            .out_data (out_data[i*DATA_W +: DATA_W]),
            .out_last (out_last[i]),
            .slot_free(slot_free[i])
        );
    end

    assign err_sel  = err_sel_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn: directed scenarios plus a randomized
// run against a packet-level reference model.
module tb_stream_demux_1xn;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_last;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_last;
    logic                     err_sel;
    logic [CNT_W-1:0]         drop_cnt;

    int checks = 0;
    int errors = 0;

    stream_demux_1xn #(
        .DATA_W(DATA_W),
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .err_sel  (err_sel),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input int sel, input int data, input logic last);
        in_valid = v;
        in_sel   = SEL_W'(sel);
        in_data  = DATA_W'(data);
        in_last  = last;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        out_ready = '1;
        #12;
        @(negedge clk);
        checks++;
        if (out_valid !== '0) begin errors++; $display("[TB] FAIL reset_valid got %h expected 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_data got %h expected 0", out_data); end
        checks++;
        if (out_last !== '0) begin errors++; $display("[TB] FAIL reset_last got %h expected 0", out_last); end
        checks++;
        if (err_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", err_sel); end
        checks++;
        if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt got %0d expected 0", drop_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        logic [NUM_CH-1:0] exp_v;
        do_reset();
        out_ready = '1;
        @(posedge clk); #1;
        for (int s = 0; s < NUM_CH; s++) begin
            drive(1'b1, s, 8'hA0 + s, 1'b1);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready ch%0d got %b expected 1", s, in_ready); end
            @(posedge clk); #1;
            exp_v = '0;
            exp_v[s] = 1'b1;
            checks++;
            if (out_valid !== exp_v) begin errors++; $display("[TB] FAIL single_valid ch%0d got %b expected %b", s, out_valid, exp_v); end
            checks++;
            if (out_data[s*DATA_W +: DATA_W] !== DATA_W'(8'hA0 + s)) begin
                errors++; $display("[TB] FAIL single_data ch%0d got %h expected %h", s, out_data[s*DATA_W +: DATA_W], 8'hA0 + s);
            end
            checks++;
            if (out_last[s] !== 1'b1) begin errors++; $display("[TB] FAIL single_last ch%0d got %b expected 1", s, out_last[s]); end
        end
        drive(1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== '0) begin errors++; $display("[TB] FAIL single_drain got %b expected 0", out_valid); end
    endtask

    task automatic test_route_lock();
        do_reset();
        out_ready = '1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0) ? 3 : 5, 8'h10 + k, k == 3);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 6'b001000) begin errors++; $display("[TB] FAIL lock_valid beat%0d got %b expected 001000", k, out_valid); end
            checks++;
            if (out_data[3*DATA_W +: DATA_W] !== DATA_W'(8'h10 + k)) begin
                errors++; $display("[TB] FAIL lock_data beat%0d got %h expected %h", k, out_data[3*DATA_W +: DATA_W], 8'h10 + k);
            end
            checks++;
            if (out_last[3] !== (k == 3)) begin errors++; $display("[TB] FAIL lock_last beat%0d got %b expected %b", k, out_last[3], k == 3); end
        end
        drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 6'b111011;
        @(posedge clk); #1;
        drive(1'b1, 2, 8'h20, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_ready got %b expected 1", in_ready); end
        @(posedge clk); #1;
        drive(1'b1, 2, 8'h21, 1'b0);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready cyc%0d got %b expected 0", w, in_ready); end
            checks++;
            if (out_valid !== 6'b000100 || out_data[2*DATA_W +: DATA_W] !== 8'h20) begin
                errors++; $display("[TB] FAIL bp_hold cyc%0d got v=%b d=%h expected v=000100 d=20", w, out_valid, out_data[2*DATA_W +: DATA_W]);
            end
            @(posedge clk); #1;
        end
        out_ready = '1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b expected 1", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 6'b000100 || out_data[2*DATA_W +: DATA_W] !== 8'h21) begin
            errors++; $display("[TB] FAIL bp_beat1 got v=%b d=%h expected v=000100 d=21", out_valid, out_data[2*DATA_W +: DATA_W]);
        end
        drive(1'b1, 2, 8'h22, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 6'b000100 || out_data[2*DATA_W +: DATA_W] !== 8'h22 || out_last[2] !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_beat2 got v=%b d=%h l=%b expected v=000100 d=22 l=1", out_valid, out_data[2*DATA_W +: DATA_W], out_last[2]);
        end
        drive(1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== '0) begin errors++; $display("[TB] FAIL bp_drain got %b expected 0", out_valid); end
    endtask

    task automatic test_drop();
        do_reset();
        out_ready = '1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, (k == 0) ? 7 : 1, 8'h90 + k, k == 2);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL drop_ready beat%0d got %b expected 1", k, in_ready); end
            @(posedge clk); #1;
            checks++;
            if (err_sel !== (k == 0)) begin errors++; $display("[TB] FAIL drop_err beat%0d got %b expected %b", k, err_sel, k == 0); end
            checks++;
            if (drop_cnt !== CNT_W'(1)) begin errors++; $display("[TB] FAIL drop_cnt beat%0d got %0d expected 1", k, drop_cnt); end
            checks++;
            if (out_valid !== '0) begin errors++; $display("[TB] FAIL drop_valid beat%0d got %b expected 0", k, out_valid); end
        end
        drive(1'b1, 1, 8'h55, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 6'b000010 || out_data[1*DATA_W +: DATA_W] !== 8'h55) begin
            errors++; $display("[TB] FAIL drop_next got v=%b d=%h expected v=000010 d=55", out_valid, out_data[1*DATA_W +: DATA_W]);
        end
        drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_saturate();
        int exp_cnt[4] = '{1, 2, 3, 3};
        do_reset();
        out_ready = '1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 6, k, 1'b1);
            @(posedge clk); #1;
            checks++;
            if (drop_cnt !== CNT_W'(exp_cnt[k])) begin errors++; $display("[TB] FAIL sat_cnt pkt%0d got %0d expected %0d", k, drop_cnt, exp_cnt[k]); end
            checks++;
            if (err_sel !== 1'b1) begin errors++; $display("[TB] FAIL sat_err pkt%0d got %b expected 1", k, err_sel); end
        end
        drive(1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (err_sel !== 1'b0) begin errors++; $display("[TB] FAIL sat_err_clear got %b expected 0", err_sel); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = '1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4, 8'h40 + k, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b1, 4, 8'h42, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== '0 || out_data !== '0 || out_last !== '0) begin
            errors++; $display("[TB] FAIL midrst_outputs got v=%b d=%h l=%b expected all 0", out_valid, out_data, out_last);
        end
        checks++;
        if (err_sel !== 1'b0 || drop_cnt !== '0) begin errors++; $display("[TB] FAIL midrst_err got e=%b c=%0d expected 0 0", err_sel, drop_cnt); end
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 0, 8'h77, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 6'b000001 || out_data[0 +: DATA_W] !== 8'h77) begin
            errors++; $display("[TB] FAIL midrst_new got v=%b d=%h expected v=000001 d=77", out_valid, out_data[0 +: DATA_W]);
        end
        drive(1'b1, 4, 8'h78, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 6'b000001 || out_data[0 +: DATA_W] !== 8'h78 || out_last[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_locked got v=%b d=%h l=%b expected v=000001 d=78 l=1", out_valid, out_data[0 +: DATA_W], out_last[0]);
        end
        drive(1'b0, 0, 0, 1'b0);
    endtask

    // Packet-level model: per-channel slot contents, packet in progress, its destination.
    task automatic test_random();
        bit             m_v[NUM_CH];
        bit [7:0]       m_d[NUM_CH];
        bit             m_l[NUM_CH];
        bit             in_pkt = 1'b0;
        bit             dropping = 1'b0;
        bit             m_err = 1'b0;
        int             cur = 0;
        int             m_drop = 0;
        int             dest;
        bit             exp_rdy;
        bit             acc;
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_v[c] = 1'b0; m_d[c] = '0; m_l[c] = 1'b0;
        end
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(3) != 0);
            in_sel   = SEL_W'($urandom_range(7));
            in_data  = DATA_W'($urandom);
            in_last  = ($urandom_range(2) == 0);
            for (int c = 0; c < NUM_CH; c++) out_ready[c] = ($urandom_range(9) < 7);
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (out_valid[c] !== m_v[c]) begin errors++; $display("[TB] FAIL rnd_valid n=%0d ch%0d got %b expected %b", n, c, out_valid[c], m_v[c]); end
                if (m_v[c]) begin
                    checks++;
                    if (out_data[c*DATA_W +: DATA_W] !== m_d[c] || out_last[c] !== m_l[c]) begin
                        errors++; $display("[TB] FAIL rnd_beat n=%0d ch%0d got d=%h l=%b expected d=%h l=%b", n, c, out_data[c*DATA_W +: DATA_W], out_last[c], m_d[c], m_l[c]);
                    end
                end
            end
            checks++;
            if (err_sel !== m_err) begin errors++; $display("[TB] FAIL rnd_err n=%0d got %b expected %b", n, err_sel, m_err); end
            checks++;
            if (drop_cnt !== CNT_W'(m_drop)) begin errors++; $display("[TB] FAIL rnd_cnt n=%0d got %0d expected %0d", n, drop_cnt, m_drop); end
            dest = in_pkt ? cur : int'(in_sel);
            if (in_pkt && dropping)             exp_rdy = 1'b1;
            else if (!in_pkt && dest >= NUM_CH) exp_rdy = 1'b1;
            else                                exp_rdy = !m_v[dest] || out_ready[dest];
            if (in_valid) begin
                checks++;
                if (in_ready !== exp_rdy) begin errors++; $display("[TB] FAIL rnd_ready n=%0d got %b expected %b", n, in_ready, exp_rdy); end
            end
            acc = in_valid && exp_rdy;
            m_err = 1'b0;
            for (int c = 0; c < NUM_CH; c++) if (out_ready[c]) m_v[c] = 1'b0;
            if (acc) begin
                if (!in_pkt && dest >= NUM_CH) begin
                    m_err = 1'b1;
                    if (m_drop < CNT_MAX) m_drop++;
                    in_pkt = !in_last;
                    dropping = 1'b1;
                end else if (in_pkt && dropping) begin
                    if (in_last) in_pkt = 1'b0;
                end else begin
                    m_v[dest] = 1'b1;
                    m_d[dest] = in_data;
                    m_l[dest] = in_last;
                    cur = dest;
                    in_pkt = !in_last;
                    dropping = 1'b0;
                end
            end
        end
        drive(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_route_lock();
        test_backpressure();
        test_drop();
        test_saturate();
        test_reset_mid_packet();
        test_random();
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
